// File: rtl/redundant_logic_unit.sv
// Redundant bitwise logic unit: R replicas of a 2-input bitwise op, each
// subject to deterministic pseudo-random single-bit faults, then
// majority-voted. Two-stage valid/ready pipeline plus a saturating
// count of delivered results that needed correction.

// One replica: applies this replica's fault (if any) to the shared base
// result. Replica index selects the LFSR rotation used as its sample.
module rlu_replica #(
  parameter int N        = 10,
  parameter int IDX      = 0,
  parameter int ERR_RATE = 0
) (
  input  logic [N-1:0] base_i,
  input  logic [15:0]  lfsr_i,
  input  logic         inject_i,
  output logic [N-1:0] rep_o
);

  logic [31:0]  rot_w;
  logic [15:0]  samp_w;
  logic [8:0]   idx_w;
  logic         hit_w;
  logic [N-1:0] flip_w;

  // Rotate-left by IDX: the upper half of the doubled word shifted left.
  assign rot_w  = {lfsr_i, lfsr_i} << IDX;
  assign samp_w = rot_w[31:16];

  // Build this replica's flip mask; the forced inject toggles bit 0 on
  // top of any random flip, so the two cancel when they land together.
  always_comb begin
    flip_w = '0;
    hit_w  = ({1'b0, samp_w[7:0]} < 9'(ERR_RATE));
    idx_w  = {1'b0, samp_w[15:8]} % 9'(N);
    for (int b = 0; b < N; b++)
      flip_w[b] = hit_w && (idx_w == 9'(b));
    flip_w[0] = flip_w[0] ^ inject_i;
    rep_o     = base_i ^ flip_w;
  end

endmodule

module redundant_logic_unit #(
  parameter int          N        = 10,
  parameter int          R        = 3,
  parameter int          ERR_RATE = 0,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [N-1:0]     x_i,
  input  logic [N-1:0]     y_i,
  input  logic             inject_i,
  output logic [N-1:0]     z_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             err_o,
  output logic [CNT_W-1:0] corr_cnt_o,
  input  logic             clear_i
);

  localparam logic [1:0] OP_NAND = 2'd0;
  localparam logic [1:0] OP_NOR  = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_AND  = 2'd3;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // [1] = stage-1 (replica regs) valid, [2] = stage-2 (output regs) valid
  logic [2:1]              vld_pipe_q, vld_pipe_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [R-1:0][N-1:0]     rep_q, rep_d;
  logic [R-1:0][N-1:0]     rep_w;
  logic [N-1:0]            z_q, z_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [N-1:0]            base_w;
  logic [N-1:0]            vote_w;
  logic                    mismatch_w;
  logic                    s2_load_w;
  logic                    accept_w;
  logic                    consume_w;
  int                      ones;

  // Handshake: stage 2 may load when empty or being drained; stage 1 may
  // take a new input when empty or when its content moves to stage 2.
  assign s2_load_w = !vld_pipe_q[2] || ready_i;
  assign ready_o   = !vld_pipe_q[1] || s2_load_w;
  assign accept_w  = valid_i && ready_o;
  assign consume_w = vld_pipe_q[2] && ready_i;

  // Fault-free operation result shared by all replicas.
  always_comb begin
    base_w = '0;
    case (op_i)
      OP_NAND: base_w = ~(x_i & y_i);
      OP_NOR:  base_w = ~(x_i | y_i);
      OP_XOR:  base_w = x_i ^ y_i;
      OP_AND:  base_w = x_i & y_i;
      default: base_w = '0;
    endcase
  end

  // Replica array; only replica 0 sees the forced inject.
  for (genvar r = 0; r < R; r++) begin : g_rep
    rlu_replica #(
      .N        (N),
      .IDX      (r),
      .ERR_RATE (ERR_RATE)
    ) u_rep (
      .base_i   (base_w),
      .lfsr_i   (lfsr_q),
      .inject_i ((r == 0) ? inject_i : 1'b0),
      .rep_o    (rep_w[r])
    );
  end

  // Bitwise majority across replicas.
  always_comb begin
    vote_w = '0;
    ones   = 0;
    for (int b = 0; b < N; b++) begin
      ones = 0;
      for (int r = 0; r < R; r++)
        ones = ones + int'(rep_q[r][b]);
      vote_w[b] = (ones > R / 2);
    end
  end

  // Any replica that disagrees with the vote marks the result corrected.
  always_comb begin
    mismatch_w = 1'b0;
    for (int r = 0; r < R; r++)
      if (rep_q[r] != vote_w) mismatch_w = 1'b1;
  end

  // LFSR advances only on accepted inputs; faults use the pre-advance value.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept_w)
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // Pipeline next-state: stage 1 captures replicas, stage 2 captures vote.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    rep_d      = rep_q;
    z_d        = z_q;
    err_d      = err_q;
    if (s2_load_w) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        z_d   = vote_w;
        err_d = mismatch_w;
      end
    end
    if (accept_w) begin
      vld_pipe_d[1] = 1'b1;
      rep_d         = rep_w;
    end else if (s2_load_w) begin
      vld_pipe_d[1] = 1'b0;
    end
  end

  // Corrected-result counter: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (consume_w && err_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      lfsr_q     <= SEED;
      rep_q      <= '0;
      z_q        <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      lfsr_q     <= lfsr_d;
      rep_q      <= rep_d;
      z_q        <= z_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign z_o        = z_q;
  assign err_o      = err_q;
  assign valid_o    = vld_pipe_q[2];
  assign corr_cnt_o = cnt_q;

endmodule

// File: tb/tb_redundant_logic_unit.sv
// Directed bench for redundant_logic_unit: three instances cover the
// fault-free default, the always-fault configuration and a 2-bit counter.
module tb_redundant_logic_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance a: defaults (N=10, R=3, ERR_RATE=0, CNT_W=16)
  logic        a_valid = 0, a_ready_o, a_inject = 0, a_valid_o, a_ready_i = 1, a_err, a_clear = 0;
  logic [1:0]  a_op = 0;
  logic [9:0]  a_x = 0, a_y = 0, a_z;
  logic [15:0] a_cnt;

  // Instance e: every replica faults
  logic        e_valid = 0, e_ready_o, e_valid_o, e_ready_i = 1, e_err;
  logic [1:0]  e_op = 0;
  logic [9:0]  e_x = 0, e_y = 0, e_z;
  logic [15:0] e_cnt;

  // Instance c: 2-bit counter
  logic        c_valid = 0, c_ready_o, c_inject = 0, c_valid_o, c_ready_i = 1, c_err, c_clear = 0;
  logic [1:0]  c_op = 0;
  logic [9:0]  c_x = 0, c_y = 0, c_z;
  logic [1:0]  c_cnt;

  redundant_logic_unit dut (
    .clk(clk), .reset_n(reset_n), .valid_i(a_valid), .ready_o(a_ready_o),
    .op_i(a_op), .x_i(a_x), .y_i(a_y), .inject_i(a_inject), .z_o(a_z),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .err_o(a_err),
    .corr_cnt_o(a_cnt), .clear_i(a_clear));

  redundant_logic_unit #(.ERR_RATE(256)) dut_e (
    .clk(clk), .reset_n(reset_n), .valid_i(e_valid), .ready_o(e_ready_o),
    .op_i(e_op), .x_i(e_x), .y_i(e_y), .inject_i(1'b0), .z_o(e_z),
    .valid_o(e_valid_o), .ready_i(e_ready_i), .err_o(e_err),
    .corr_cnt_o(e_cnt), .clear_i(1'b0));

  redundant_logic_unit #(.CNT_W(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .valid_i(c_valid), .ready_o(c_ready_o),
    .op_i(c_op), .x_i(c_x), .y_i(c_y), .inject_i(c_inject), .z_o(c_z),
    .valid_o(c_valid_o), .ready_i(c_ready_i), .err_o(c_err),
    .corr_cnt_o(c_cnt), .clear_i(c_clear));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference for ERR_RATE=256, R=3, N=10: each replica always flips one bit.
  function automatic void model(input logic [1:0] op, input logic [9:0] x,
                                input logic [9:0] y, input logic [15:0] l,
                                output logic [9:0] z, output logic e);
    logic [9:0]  base;
    logic [9:0]  rp [3];
    logic [15:0] s;
    int          idx;
    case (op)
      2'd0: base = ~(x & y);
      2'd1: base = ~(x | y);
      2'd2: base = x ^ y;
      default: base = x & y;
    endcase
    for (int r = 0; r < 3; r++) begin
      s = l;
      for (int k = 0; k < r; k++) s = {s[14:0], s[15]};
      idx = int'(s[15:8]) % 10;
      rp[r] = base ^ (10'd1 << idx);
    end
    z = (rp[0] & rp[1]) | (rp[0] & rp[2]) | (rp[1] & rp[2]);
    e = (rp[0] != z) || (rp[1] != z) || (rp[2] != z);
  endfunction

  task automatic test_reset();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid_o); end
    n_checks++; if (a_z !== 10'h000) begin n_fail++; $display("FAIL reset_z: got %h want 000", a_z); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", a_err); end
    n_checks++; if (a_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", a_cnt); end
    n_checks++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_ready_o); end
  endtask

  task automatic test_basic();
    a_op = 2'd0; a_x = 10'h3FF; a_y = 10'h001; a_valid = 1;
    tick();
    a_valid = 0;
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", a_valid_o); end
    tick();
    n_checks++; if (a_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", a_valid_o); end
    n_checks++; if (a_z !== 10'h3FE) begin n_fail++; $display("FAIL basic_z: got %h want 3fe", a_z); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", a_err); end
    tick();
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", a_valid_o); end
  endtask

  task automatic test_stream();
    logic [9:0] exp_z [4];
    exp_z[0] = 10'h35F; exp_z[1] = 10'h105; exp_z[2] = 10'h25A; exp_z[3] = 10'h0A0;
    a_x = 10'h2AA; a_y = 10'h0F0; a_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      a_valid = (i < 4);
      a_op = 2'(i);
      tick();
      if (i >= 1) begin
        n_checks++; if (a_valid_o !== 1'b1 || a_z !== exp_z[i-1])
          begin n_fail++; $display("FAIL stream_op%0d: got v=%b z=%h want v=1 z=%h", i-1, a_valid_o, a_z, exp_z[i-1]); end
      end
    end
    a_valid = 0;
    tick(); tick();
    n_checks++; if (a_cnt !== 16'h0) begin n_fail++; $display("FAIL stream_cnt: got %0d want 0", a_cnt); end
  endtask

  task automatic test_inject();
    a_op = 2'd3; a_x = 10'h001; a_y = 10'h001; a_inject = 1; a_valid = 1;
    tick();
    a_valid = 0; a_inject = 0;
    tick();
    n_checks++; if (a_valid_o !== 1'b1 || a_z !== 10'h001) begin n_fail++; $display("FAIL inject_z: got v=%b z=%h want v=1 z=001", a_valid_o, a_z); end
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL inject_err: got %b want 1", a_err); end
    tick();
    n_checks++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL inject_cnt: got %0d want 1", a_cnt); end
  endtask

  task automatic test_backpressure();
    logic [1:0] ops [3];
    logic [9:0] xs [3], ys [3], ez [3];
    int sent = 0, got = 0;
    logic acc, cons;
    ops[0] = 2'd2; xs[0] = 10'h155; ys[0] = 10'h0FF; ez[0] = 10'h1AA;
    ops[1] = 2'd3; xs[1] = 10'h3C3; ys[1] = 10'h0FF; ez[1] = 10'h0C3;
    ops[2] = 2'd1; xs[2] = 10'h100; ys[2] = 10'h001; ez[2] = 10'h2FE;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      a_ready_i = (cyc >= 5);
      a_valid = (sent < 3);
      if (sent < 3) begin a_op = ops[sent]; a_x = xs[sent]; a_y = ys[sent]; end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++; if (a_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want 0", cyc, a_ready_o); end
      end
      if (cyc == 4) begin
        n_checks++; if (sent != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", sent); end
      end
      if (a_valid_o && !a_ready_i) begin
        n_checks++; if (a_z !== ez[got]) begin n_fail++; $display("FAIL bp_hold_c%0d: got %h want %h", cyc, a_z, ez[got]); end
      end
      acc = a_valid && a_ready_o;
      cons = a_valid_o && a_ready_i;
      if (cons) begin
        n_checks++; if (a_z !== ez[got]) begin n_fail++; $display("FAIL bp_out%0d: got %h want %h", got, a_z, ez[got]); end
        got++;
      end
      tick();
      if (acc) sent++;
    end
    a_valid = 0; a_ready_i = 1;
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got); end
    tick();
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_extra: got %b want 0", a_valid_o); end
  endtask

  task automatic test_err_rate();
    logic [15:0] l = 16'hACE1;
    logic [9:0]  qz [$];
    logic        qe [$];
    logic [9:0]  mz;
    logic        me;
    int sent = 0, got = 0, nerr = 0;
    e_ready_i = 1;
    for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
      e_valid = (sent < 100);
      e_op = 2'(sent % 4);
      e_x = 10'((sent * 37) & 10'h3FF);
      e_y = 10'((sent * 91 + 5) & 10'h3FF);
      #1;
      if (e_valid_o) begin
        n_checks++;
        if (qz.size() == 0) begin n_fail++; $display("FAIL err_unexpected: got output with empty queue"); end
        else begin
          mz = qz.pop_front(); me = qe.pop_front();
          if (e_z !== mz || e_err !== me) begin n_fail++; $display("FAIL err_txn%0d: got z=%h e=%b want z=%h e=%b", got, e_z, e_err, mz, me); end
          if (me) nerr++;
        end
        got++;
      end
      if (e_valid && e_ready_o) begin
        model(e_op, e_x, e_y, l, mz, me);
        qz.push_back(mz); qe.push_back(me);
        l = lfsr_next(l);
        sent++;
      end
      tick();
    end
    e_valid = 0;
    n_checks++; if (got != 100) begin n_fail++; $display("FAIL err_count: got %0d want 100", got); end
    n_checks++; if (e_cnt !== 16'(nerr)) begin n_fail++; $display("FAIL err_cnt: got %0d want %0d", e_cnt, nerr); end
  endtask

  task automatic test_saturate();
    c_ready_i = 1; c_op = 2'd3; c_x = 10'h001; c_y = 10'h001; c_inject = 1;
    c_valid = 1;
    for (int i = 0; i < 5; i++) tick();
    c_valid = 0; c_inject = 0;
    tick(); tick(); tick();
    n_checks++; if (c_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d want 3", c_cnt); end
    c_clear = 1; tick(); c_clear = 0;
    n_checks++; if (c_cnt !== 2'd0) begin n_fail++; $display("FAIL clear_cnt: got %0d want 0", c_cnt); end
    c_inject = 1; c_valid = 1; tick();
    c_inject = 0; c_valid = 0; tick();
    c_clear = 1;
    n_checks++; if (c_valid_o !== 1'b1 || c_err !== 1'b1) begin n_fail++; $display("FAIL clear_txn: got v=%b e=%b want v=1 e=1", c_valid_o, c_err); end
    tick(); c_clear = 0;
    n_checks++; if (c_cnt !== 2'd0) begin n_fail++; $display("FAIL clear_prio: got %0d want 0", c_cnt); end
    c_inject = 1; c_valid = 1; tick();
    c_inject = 0; c_valid = 0; tick(); tick();
    n_checks++; if (c_cnt !== 2'd1) begin n_fail++; $display("FAIL cnt_after_clear: got %0d want 1", c_cnt); end
  endtask

  task automatic test_reset_midflight();
    logic [9:0] mz;
    logic       me;
    e_ready_i = 1; e_op = 2'd2; e_x = 10'h123; e_y = 10'h0F0; e_valid = 1;
    a_ready_i = 1; a_op = 2'd3; a_x = 10'h3FF; a_y = 10'h3FF; a_valid = 1;
    tick(); tick();
    e_valid = 0; a_valid = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    n_checks++; if (e_valid_o !== 1'b0 || a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got e=%b a=%b want 0", e_valid_o, a_valid_o); end
    n_checks++; if (a_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d want 0", a_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (e_valid_o !== 1'b0 || a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_ghost_c%0d: got e=%b a=%b want 0", i, e_valid_o, a_valid_o); end
    end
    // First transaction after reset must use the seed again.
    e_op = 2'd0; e_x = 10'h3FF; e_y = 10'h001; e_valid = 1;
    model(e_op, e_x, e_y, 16'hACE1, mz, me);
    tick(); e_valid = 0; tick();
    n_checks++; if (e_valid_o !== 1'b1 || e_z !== mz || e_err !== me) begin n_fail++; $display("FAIL rst_seed: got v=%b z=%h e=%b want v=1 z=%h e=%b", e_valid_o, e_z, e_err, mz, me); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_inject();
    test_backpressure();
    test_err_rate();
    test_saturate();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
